// File: rtl/alu_issue_queue.sv
// Eight-entry compacting issue queue with oldest-first dual select for ALU0/ALU1.
// Entries stay packed at the low indices; each posedge rebuilds survivors then appends dispatches.

module iq_wake_match (
    input  logic [5:0]      tag,
    input  logic [3:0][5:0] bus_tag,
    input  logic [3:0]      bus_vld,
    output logic            hit
);
    // Tag 0 is the hardwired-ready register.
    always_comb begin
        hit = (tag == 6'd0);
        for (int b = 0; b < 4; b++)
            if (bus_vld[b] && bus_tag[b] == tag) hit = 1'b1;
    end
endmodule

module alu_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 Inst1_Valid,
    input  logic [5:0]           Inst1_Src1,
    input  logic [5:0]           Inst1_Src2,
    input  logic [5:0]           Inst1_Phydst,
    input  logic                 Inst1_Src1_Wake,
    input  logic                 Inst1_Src2_Wake,
    input  logic [PAYLOAD_W-1:0] Inst1_Payload,
    input  logic                 Inst2_Valid,
    input  logic [5:0]           Inst2_Src1,
    input  logic [5:0]           Inst2_Src2,
    input  logic [5:0]           Inst2_Phydst,
    input  logic                 Inst2_Src1_Wake,
    input  logic                 Inst2_Src2_Wake,
    input  logic [PAYLOAD_W-1:0] Inst2_Payload,
    input  logic [5:0]           ALU0_Phydst,
    input  logic                 ALU0_wake,
    input  logic [5:0]           ALU1_Phydst,
    input  logic                 ALU1_wake,
    input  logic [5:0]           BU_Phydst,
    input  logic                 BU_wake,
    input  logic [5:0]           DU_Phydst,
    input  logic                 DU_wake,
    input  logic                 ALU0_Busy,
    input  logic                 ALU1_Busy,
    output logic                 Dispatch_Stall,
    output logic                 ALU0_Issue_Valid,
    output logic [5:0]           ALU0_Issue_Phydst,
    output logic [5:0]           ALU0_Issue_Src1,
    output logic [5:0]           ALU0_Issue_Src2,
    output logic [PAYLOAD_W-1:0] ALU0_Issue_Payload,
    output logic                 ALU1_Issue_Valid,
    output logic [5:0]           ALU1_Issue_Phydst,
    output logic [5:0]           ALU1_Issue_Src1,
    output logic [5:0]           ALU1_Issue_Src2,
    output logic [PAYLOAD_W-1:0] ALU1_Issue_Payload,
    output logic [3:0]           IQ_Count
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [5:0]           src1;
        logic [5:0]           src2;
        logic [5:0]           dst;
        logic                 rdy1;
        logic                 rdy2;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t [DEPTH-1:0]        ent_q, nxt_ent, upd;
    logic   [DEPTH-1:0]        vld_q, nxt_vld, rdy, surv, hit1, hit2;
    logic   [DEPTH-1:0]        o1_oh, o2_oh, rest, iss0_oh, iss1_oh;
    logic   [DEPTH-1:0][CW-1:0] pos;
    logic   [CW-1:0]           cnt_q, nxt_cnt, nsurv, slot2;
    logic   [3:0][5:0]         wtag;
    logic   [3:0]              wvld, dhit;
    entry_t                    d1, d2, e0, e1;
    logic                      acc1, acc2;

    assign wtag = {DU_Phydst, BU_Phydst, ALU1_Phydst, ALU0_Phydst};
    assign wvld = {DU_wake, BU_wake, ALU1_wake, ALU0_wake};

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_ent
        iq_wake_match u_m1 (.tag(ent_q[g].src1), .bus_tag(wtag), .bus_vld(wvld), .hit(hit1[g]));
        iq_wake_match u_m2 (.tag(ent_q[g].src2), .bus_tag(wtag), .bus_vld(wvld), .hit(hit2[g]));
        assign upd[g] = {ent_q[g].src1, ent_q[g].src2, ent_q[g].dst,
                         ent_q[g].rdy1 | hit1[g], ent_q[g].rdy2 | hit2[g], ent_q[g].payload};
        assign rdy[g] = vld_q[g] & ent_q[g].rdy1 & ent_q[g].rdy2;
    end

    // Dispatch-cycle bypass: a wake seen alongside the dispatch is captured directly.
    iq_wake_match u_d11 (.tag(Inst1_Src1), .bus_tag(wtag), .bus_vld(wvld), .hit(dhit[0]));
    iq_wake_match u_d12 (.tag(Inst1_Src2), .bus_tag(wtag), .bus_vld(wvld), .hit(dhit[1]));
    iq_wake_match u_d21 (.tag(Inst2_Src1), .bus_tag(wtag), .bus_vld(wvld), .hit(dhit[2]));
    iq_wake_match u_d22 (.tag(Inst2_Src2), .bus_tag(wtag), .bus_vld(wvld), .hit(dhit[3]));

    assign d1 = {Inst1_Src1, Inst1_Src2, Inst1_Phydst,
                 Inst1_Src1_Wake | dhit[0], Inst1_Src2_Wake | dhit[1], Inst1_Payload};
    assign d2 = {Inst2_Src1, Inst2_Src2, Inst2_Phydst,
                 Inst2_Src1_Wake | dhit[2], Inst2_Src2_Wake | dhit[3], Inst2_Payload};

    assign Dispatch_Stall = cnt_q > CW'(DEPTH - 2);
    assign IQ_Count       = 4'(cnt_q);
    assign acc1           = !flush && !Dispatch_Stall && Inst1_Valid;
    assign acc2           = !flush && !Dispatch_Stall && Inst2_Valid;

    // Lowest and second-lowest ready entries as one-hot vectors.
    assign o1_oh = rdy & (-rdy);
    assign rest  = rdy & ~o1_oh;
    assign o2_oh = rest & (-rest);

    always_comb begin
        iss0_oh = '0;
        iss1_oh = '0;
        case ({ALU1_Busy, ALU0_Busy})
            2'b00: begin iss0_oh = o1_oh; iss1_oh = o2_oh; end
            2'b01: iss1_oh = o1_oh;
            2'b10: iss0_oh = o1_oh;
            default: ;
        endcase
    end

    always_comb begin
        e0 = '0;
        e1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss0_oh[i]) e0 = ent_q[i];
            if (iss1_oh[i]) e1 = ent_q[i];
        end
    end

    assign surv = vld_q & ~(iss0_oh | iss1_oh);

    always_comb begin
        nsurv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pos[i] = nsurv;
            nsurv  = nsurv + CW'(surv[i]);
        end
    end

    assign slot2   = nsurv + CW'(acc1);
    assign nxt_cnt = slot2 + CW'(acc2);

    // Each destination slot picks the survivor of matching rank, else a dispatch.
    always_comb begin
        nxt_vld = '0;
        nxt_ent = ent_q;
        for (int j = 0; j < DEPTH; j++) begin
            for (int i = 0; i < DEPTH; i++)
                if (surv[i] && pos[i] == CW'(j)) begin
                    nxt_vld[j] = 1'b1;
                    nxt_ent[j] = upd[i];
                end
            if (acc1 && nsurv == CW'(j)) begin
                nxt_vld[j] = 1'b1;
                nxt_ent[j] = d1;
            end
            if (acc2 && slot2 == CW'(j)) begin
                nxt_vld[j] = 1'b1;
                nxt_ent[j] = d2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q              <= '0;
            ent_q              <= '0;
            cnt_q              <= '0;
            ALU0_Issue_Valid   <= 1'b0;
            ALU0_Issue_Phydst  <= '0;
            ALU0_Issue_Src1    <= '0;
            ALU0_Issue_Src2    <= '0;
            ALU0_Issue_Payload <= '0;
            ALU1_Issue_Valid   <= 1'b0;
            ALU1_Issue_Phydst  <= '0;
            ALU1_Issue_Src1    <= '0;
            ALU1_Issue_Src2    <= '0;
            ALU1_Issue_Payload <= '0;
        end else if (flush) begin
            vld_q            <= '0;
            cnt_q            <= '0;
            ALU0_Issue_Valid <= 1'b0;
            ALU1_Issue_Valid <= 1'b0;
        end else begin
            vld_q            <= nxt_vld;
            ent_q            <= nxt_ent;
            cnt_q            <= nxt_cnt;
            ALU0_Issue_Valid <= |iss0_oh;
            ALU1_Issue_Valid <= |iss1_oh;
            if (|iss0_oh) begin
                ALU0_Issue_Phydst  <= e0.dst;
                ALU0_Issue_Src1    <= e0.src1;
                ALU0_Issue_Src2    <= e0.src2;
                ALU0_Issue_Payload <= e0.payload;
            end
            if (|iss1_oh) begin
                ALU1_Issue_Phydst  <= e1.dst;
                ALU1_Issue_Src1    <= e1.src1;
                ALU1_Issue_Src2    <= e1.src2;
                ALU1_Issue_Payload <= e1.payload;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Queue-based reference model with per-cycle output compare, directed scenarios, then random traffic.

module tb_alu_issue_queue;
    localparam int DEPTH = 8;
    localparam int PW    = 32;

    logic clk, rst, flush;
    logic Inst1_Valid, Inst1_Src1_Wake, Inst1_Src2_Wake;
    logic [5:0] Inst1_Src1, Inst1_Src2, Inst1_Phydst;
    logic [PW-1:0] Inst1_Payload;
    logic Inst2_Valid, Inst2_Src1_Wake, Inst2_Src2_Wake;
    logic [5:0] Inst2_Src1, Inst2_Src2, Inst2_Phydst;
    logic [PW-1:0] Inst2_Payload;
    logic [5:0] ALU0_Phydst, ALU1_Phydst, BU_Phydst, DU_Phydst;
    logic ALU0_wake, ALU1_wake, BU_wake, DU_wake, ALU0_Busy, ALU1_Busy;
    logic Dispatch_Stall, ALU0_Issue_Valid, ALU1_Issue_Valid;
    logic [5:0] ALU0_Issue_Phydst, ALU0_Issue_Src1, ALU0_Issue_Src2;
    logic [5:0] ALU1_Issue_Phydst, ALU1_Issue_Src1, ALU1_Issue_Src2;
    logic [PW-1:0] ALU0_Issue_Payload, ALU1_Issue_Payload;
    logic [3:0] IQ_Count;

    alu_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .Inst1_Valid(Inst1_Valid), .Inst1_Src1(Inst1_Src1), .Inst1_Src2(Inst1_Src2),
        .Inst1_Phydst(Inst1_Phydst), .Inst1_Src1_Wake(Inst1_Src1_Wake),
        .Inst1_Src2_Wake(Inst1_Src2_Wake), .Inst1_Payload(Inst1_Payload),
        .Inst2_Valid(Inst2_Valid), .Inst2_Src1(Inst2_Src1), .Inst2_Src2(Inst2_Src2),
        .Inst2_Phydst(Inst2_Phydst), .Inst2_Src1_Wake(Inst2_Src1_Wake),
        .Inst2_Src2_Wake(Inst2_Src2_Wake), .Inst2_Payload(Inst2_Payload),
        .ALU0_Phydst(ALU0_Phydst), .ALU0_wake(ALU0_wake),
        .ALU1_Phydst(ALU1_Phydst), .ALU1_wake(ALU1_wake),
        .BU_Phydst(BU_Phydst), .BU_wake(BU_wake),
        .DU_Phydst(DU_Phydst), .DU_wake(DU_wake),
        .ALU0_Busy(ALU0_Busy), .ALU1_Busy(ALU1_Busy),
        .Dispatch_Stall(Dispatch_Stall),
        .ALU0_Issue_Valid(ALU0_Issue_Valid), .ALU0_Issue_Phydst(ALU0_Issue_Phydst),
        .ALU0_Issue_Src1(ALU0_Issue_Src1), .ALU0_Issue_Src2(ALU0_Issue_Src2),
        .ALU0_Issue_Payload(ALU0_Issue_Payload),
        .ALU1_Issue_Valid(ALU1_Issue_Valid), .ALU1_Issue_Phydst(ALU1_Issue_Phydst),
        .ALU1_Issue_Src1(ALU1_Issue_Src1), .ALU1_Issue_Src2(ALU1_Issue_Src2),
        .ALU1_Issue_Payload(ALU1_Issue_Payload),
        .IQ_Count(IQ_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    typedef struct {
        logic [5:0]    s1, s2, d;
        bit            r1, r2;
        logic [PW-1:0] p;
    } ment_t;

    ment_t mq[$];
    bit m_v0, m_v1;
    logic [5:0] m_d0, m_a0, m_b0, m_d1, m_a1, m_b1;
    logic [PW-1:0] m_p0, m_p1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit woken(input logic [5:0] t);
        return t == 6'd0 || (ALU0_wake && ALU0_Phydst == t) || (ALU1_wake && ALU1_Phydst == t) ||
               (BU_wake && BU_Phydst == t) || (DU_wake && DU_Phydst == t);
    endfunction

    // One clock of the reference: pick, remove, wake survivors, append accepted dispatches.
    task automatic model_step();
        int rl[$];
        int a0, a1;
        bit stall;
        ment_t nq[$];
        ment_t e;
        a0 = -1;
        a1 = -1;
        if (rst) begin
            mq.delete();
            m_v0 = 0; m_v1 = 0;
            m_d0 = 0; m_a0 = 0; m_b0 = 0; m_p0 = 0;
            m_d1 = 0; m_a1 = 0; m_b1 = 0; m_p1 = 0;
        end else if (flush) begin
            mq.delete();
            m_v0 = 0; m_v1 = 0;
        end else begin
            stall = mq.size() > DEPTH - 2;
            foreach (mq[i]) if (mq[i].r1 && mq[i].r2 && rl.size() < 2) rl.push_back(i);
            if (!ALU0_Busy && !ALU1_Busy) begin
                if (rl.size() > 0) a0 = rl[0];
                if (rl.size() > 1) a1 = rl[1];
            end else if (ALU0_Busy && !ALU1_Busy) begin
                if (rl.size() > 0) a1 = rl[0];
            end else if (!ALU0_Busy) begin
                if (rl.size() > 0) a0 = rl[0];
            end
            m_v0 = a0 >= 0;
            m_v1 = a1 >= 0;
            if (a0 >= 0) begin m_d0 = mq[a0].d; m_a0 = mq[a0].s1; m_b0 = mq[a0].s2; m_p0 = mq[a0].p; end
            if (a1 >= 0) begin m_d1 = mq[a1].d; m_a1 = mq[a1].s1; m_b1 = mq[a1].s2; m_p1 = mq[a1].p; end
            foreach (mq[i]) if (i != a0 && i != a1) begin
                e = mq[i];
                e.r1 = e.r1 | woken(e.s1);
                e.r2 = e.r2 | woken(e.s2);
                nq.push_back(e);
            end
            if (!stall && Inst1_Valid) begin
                e = '{Inst1_Src1, Inst1_Src2, Inst1_Phydst, Inst1_Src1_Wake | woken(Inst1_Src1),
                      Inst1_Src2_Wake | woken(Inst1_Src2), Inst1_Payload};
                nq.push_back(e);
            end
            if (!stall && Inst2_Valid) begin
                e = '{Inst2_Src1, Inst2_Src2, Inst2_Phydst, Inst2_Src1_Wake | woken(Inst2_Src1),
                      Inst2_Src2_Wake | woken(Inst2_Src2), Inst2_Payload};
                nq.push_back(e);
            end
            mq = nq;
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("a0_valid", 64'(ALU0_Issue_Valid), 64'(m_v0));
        chk("a1_valid", 64'(ALU1_Issue_Valid), 64'(m_v1));
        chk("a0_dst",   64'(ALU0_Issue_Phydst), 64'(m_d0));
        chk("a0_src1",  64'(ALU0_Issue_Src1), 64'(m_a0));
        chk("a0_src2",  64'(ALU0_Issue_Src2), 64'(m_b0));
        chk("a0_pl",    64'(ALU0_Issue_Payload), 64'(m_p0));
        chk("a1_dst",   64'(ALU1_Issue_Phydst), 64'(m_d1));
        chk("a1_src1",  64'(ALU1_Issue_Src1), 64'(m_a1));
        chk("a1_src2",  64'(ALU1_Issue_Src2), 64'(m_b1));
        chk("a1_pl",    64'(ALU1_Issue_Payload), 64'(m_p1));
        chk("count",    64'(IQ_Count), 64'(mq.size()));
        chk("stall",    64'(Dispatch_Stall), 64'(mq.size() > DEPTH - 2));
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr();
        flush = 0;
        Inst1_Valid = 0; Inst1_Src1 = 0; Inst1_Src2 = 0; Inst1_Phydst = 0;
        Inst1_Src1_Wake = 0; Inst1_Src2_Wake = 0; Inst1_Payload = 0;
        Inst2_Valid = 0; Inst2_Src1 = 0; Inst2_Src2 = 0; Inst2_Phydst = 0;
        Inst2_Src1_Wake = 0; Inst2_Src2_Wake = 0; Inst2_Payload = 0;
        ALU0_Phydst = 0; ALU1_Phydst = 0; BU_Phydst = 0; DU_Phydst = 0;
        ALU0_wake = 0; ALU1_wake = 0; BU_wake = 0; DU_wake = 0;
        ALU0_Busy = 0; ALU1_Busy = 0;
    endtask

    task automatic rand_in();
        flush = $urandom_range(0, 99) < 2;
        Inst1_Valid = $urandom_range(0, 99) < 60;
        Inst1_Src1 = 6'($urandom_range(0, 15)); Inst1_Src2 = 6'($urandom_range(0, 15));
        Inst1_Phydst = 6'($urandom_range(0, 63));
        Inst1_Src1_Wake = $urandom_range(0, 2) == 0; Inst1_Src2_Wake = $urandom_range(0, 2) == 0;
        Inst1_Payload = $urandom;
        Inst2_Valid = $urandom_range(0, 99) < 50;
        Inst2_Src1 = 6'($urandom_range(0, 15)); Inst2_Src2 = 6'($urandom_range(0, 15));
        Inst2_Phydst = 6'($urandom_range(0, 63));
        Inst2_Src1_Wake = $urandom_range(0, 2) == 0; Inst2_Src2_Wake = $urandom_range(0, 2) == 0;
        Inst2_Payload = $urandom;
        ALU0_Phydst = 6'($urandom_range(0, 15)); ALU0_wake = $urandom_range(0, 3) == 0;
        ALU1_Phydst = 6'($urandom_range(0, 15)); ALU1_wake = $urandom_range(0, 3) == 0;
        BU_Phydst   = 6'($urandom_range(0, 15)); BU_wake   = $urandom_range(0, 3) == 0;
        DU_Phydst   = 6'($urandom_range(0, 15)); DU_wake   = $urandom_range(0, 3) == 0;
        ALU0_Busy = $urandom_range(0, 4) == 0;
        ALU1_Busy = $urandom_range(0, 4) == 0;
    endtask

    initial begin
        clr();
        rst = 1;
        cyc();
        chk_en = 1;
        cyc();
        rst = 0;
        chk("rst_a0v", 64'(ALU0_Issue_Valid), 64'd0);
        chk("rst_a1v", 64'(ALU1_Issue_Valid), 64'd0);
        chk("rst_cnt", 64'(IQ_Count), 64'd0);
        chk("rst_stall", 64'(Dispatch_Stall), 64'd0);
        chk("rst_pl", 64'(ALU1_Issue_Payload), 64'd0);

        // Single ready dispatch: issue two cycles later on ALU0.
        Inst1_Valid = 1; Inst1_Src1 = 5; Inst1_Src2 = 6; Inst1_Phydst = 10;
        Inst1_Src1_Wake = 1; Inst1_Src2_Wake = 1; Inst1_Payload = 32'hABCD;
        cyc(); clr();
        chk("simple_cnt1", 64'(IQ_Count), 64'd1);
        chk("simple_v0a", 64'(ALU0_Issue_Valid), 64'd0);
        cyc();
        chk("simple_v0", 64'(ALU0_Issue_Valid), 64'd1);
        chk("simple_dst", 64'(ALU0_Issue_Phydst), 64'd10);
        chk("simple_pl", 64'(ALU0_Issue_Payload), 64'hABCD);
        chk("simple_cnt0", 64'(IQ_Count), 64'd0);

        // Age order around a blocked older entry, then wake it via BU.
        Inst1_Valid = 1; Inst1_Src1 = 20; Inst1_Phydst = 11;
        cyc(); clr();
        Inst1_Valid = 1; Inst1_Src1 = 1; Inst1_Src2 = 2; Inst1_Phydst = 12;
        Inst1_Src1_Wake = 1; Inst1_Src2_Wake = 1;
        Inst2_Valid = 1; Inst2_Src1 = 3; Inst2_Src2 = 4; Inst2_Phydst = 13;
        Inst2_Src1_Wake = 1; Inst2_Src2_Wake = 1;
        cyc(); clr();
        cyc();
        chk("age_v0", 64'(ALU0_Issue_Valid), 64'd1);
        chk("age_d0", 64'(ALU0_Issue_Phydst), 64'd12);
        chk("age_v1", 64'(ALU1_Issue_Valid), 64'd1);
        chk("age_d1", 64'(ALU1_Issue_Phydst), 64'd13);
        chk("age_cnt", 64'(IQ_Count), 64'd1);
        BU_wake = 1; BU_Phydst = 20;
        cyc(); clr();
        cyc();
        chk("wake_v0", 64'(ALU0_Issue_Valid), 64'd1);
        chk("wake_d0", 64'(ALU0_Issue_Phydst), 64'd11);
        chk("wake_cnt", 64'(IQ_Count), 64'd0);

        // Dispatch-cycle bypass from DU.
        Inst1_Valid = 1; Inst1_Src1 = 33; Inst1_Phydst = 14;
        DU_wake = 1; DU_Phydst = 33;
        cyc(); clr();
        cyc();
        chk("byp_v0", 64'(ALU0_Issue_Valid), 64'd1);
        chk("byp_d0", 64'(ALU0_Issue_Phydst), 64'd14);

        // ALU0 busy: oldest goes to ALU1, the other follows on ALU0.
        Inst1_Valid = 1; Inst1_Src1 = 7; Inst1_Src1_Wake = 1; Inst1_Phydst = 21;
        Inst2_Valid = 1; Inst2_Src1 = 8; Inst2_Src1_Wake = 1; Inst2_Phydst = 22;
        cyc(); clr();
        ALU0_Busy = 1;
        cyc(); clr();
        chk("busy_v0", 64'(ALU0_Issue_Valid), 64'd0);
        chk("busy_v1", 64'(ALU1_Issue_Valid), 64'd1);
        chk("busy_d1", 64'(ALU1_Issue_Phydst), 64'd21);
        cyc();
        chk("busy2_v0", 64'(ALU0_Issue_Valid), 64'd1);
        chk("busy2_d0", 64'(ALU0_Issue_Phydst), 64'd22);

        // Fill to seven blocked entries, confirm stall holds extra requests off.
        for (int k = 0; k < 4; k++) begin
            Inst1_Valid = 1; Inst1_Src1 = 6'(40 + 2 * k); Inst1_Phydst = 6'(30 + 2 * k);
            Inst2_Valid = (k < 3); Inst2_Src1 = 6'(41 + 2 * k); Inst2_Phydst = 6'(31 + 2 * k);
            cyc(); clr();
        end
        chk("full_cnt", 64'(IQ_Count), 64'd7);
        chk("full_stall", 64'(Dispatch_Stall), 64'd1);
        Inst1_Valid = 1; Inst1_Src1 = 50; Inst2_Valid = 1; Inst2_Src1 = 51;
        cyc(); clr();
        chk("full_hold", 64'(IQ_Count), 64'd7);
        ALU1_wake = 1; ALU1_Phydst = 40;
        cyc(); clr();
        cyc();
        chk("drain_v0", 64'(ALU0_Issue_Valid), 64'd1);
        chk("drain_d0", 64'(ALU0_Issue_Phydst), 64'd30);
        chk("drain_cnt", 64'(IQ_Count), 64'd6);
        chk("drain_stall", 64'(Dispatch_Stall), 64'd0);

        // Flush with a concurrent dispatch; stale wake afterwards issues nothing.
        flush = 1; Inst1_Valid = 1; Inst1_Src1_Wake = 1; Inst1_Src2_Wake = 1; Inst1_Phydst = 60;
        cyc(); clr();
        chk("flush_cnt", 64'(IQ_Count), 64'd0);
        chk("flush_v0", 64'(ALU0_Issue_Valid), 64'd0);
        chk("flush_v1", 64'(ALU1_Issue_Valid), 64'd0);
        ALU0_wake = 1; ALU0_Phydst = 41;
        cyc(); clr();
        cyc();
        chk("stale_v0", 64'(ALU0_Issue_Valid), 64'd0);
        chk("stale_cnt", 64'(IQ_Count), 64'd0);

        for (int n = 0; n < 4000; n++) begin
            rand_in();
            cyc();
        end
        clr();
        cyc();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
